// File: rtl/hazard_unit.sv
// Pipeline control for a 5-stage CPU: decides per cycle which latches advance, hold or flush,
// tracks the stall cause in a small FSM and keeps saturating stall/flush statistics.
module hazard_unit #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             memRead_ex,
  input  logic [REG_W-1:0] regSel_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             pcSrc_mem,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LUSE   = 2'd1,
    DWAIT  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t cur_state, nxt_state;
  logic   dmiss, luse, halting, redirect;

  assign dmiss   = (dmemREN_mem | dmemWEN_mem) & ~dhit;
  assign luse    = memRead_ex & (regSel_ex != '0) &
                   ((regSel_ex == rs_id) | (regSel_ex == rt_id));
  assign halting = (cur_state == HALTED) | halt_wb;
  // A redirect only counts when neither halt nor a dcache freeze overrides it.
  assign redirect = ~nRST & ~halting & ~dmiss & pcSrc_mem;
  assign state    = cur_state;

  always_ff @(posedge CLK) begin
    if (nRST) begin
      cur_state <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      if (!pc_en && !halt && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      if (redirect && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  always_comb begin
    nxt_state = RUN;
    if (halting)                nxt_state = HALTED;
    else if (dmiss)             nxt_state = DWAIT;
    else if (luse && !pcSrc_mem) nxt_state = LUSE;
  end

  always_comb begin
    pc_en       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    halt        = 1'b0;
    if (nRST) begin
      pc_en       = 1'b0;
      en_ifid     = 1'b0;
      en_idex     = 1'b0;
      en_exmem    = 1'b0;
      en_memwb    = 1'b0;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (halting || dmiss) begin
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
      halt     = halting;
    end else if (pcSrc_mem) begin
      // Target PC loads even on an icache miss; the wrong-path instructions are squashed.
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (luse) begin
      pc_en      = 1'b0;
      en_ifid    = 1'b0;
      flush_idex = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      flush_ifid = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a behavioural reference model pushes expected
// outputs into a queue per driven cycle; each entry is popped and compared mid-cycle.
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       nRST, ihit, dhit, dmemREN_mem, dmemWEN_mem, memRead_ex, pcSrc_mem, halt_wb;
  logic [4:0] regSel_ex, rs_id, rt_id;
  logic       pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic       flush_ifid, flush_idex, flush_exmem, halt;
  logic [1:0] state, state4;
  logic [15:0] stall_cnt, flush_cnt;
  logic       pc_en4, en_ifid4, en_idex4, en_exmem4, en_memwb4;
  logic       flush_ifid4, flush_idex4, flush_exmem4, halt4;
  logic [3:0] stall_cnt4, flush_cnt4;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  // reference model state
  logic [1:0]  m_state;
  logic [15:0] m_stall, m_flush;
  logic [3:0]  m_stall4;

  always #5 CLK = ~CLK;

  hazard_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
    .memRead_ex(memRead_ex), .regSel_ex(regSel_ex), .rs_id(rs_id), .rt_id(rt_id),
    .pcSrc_mem(pcSrc_mem), .halt_wb(halt_wb),
    .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
    .en_memwb(en_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .halt(halt), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
    .memRead_ex(memRead_ex), .regSel_ex(regSel_ex), .rs_id(rs_id), .rt_id(rt_id),
    .pcSrc_mem(pcSrc_mem), .halt_wb(halt_wb),
    .pc_en(pc_en4), .en_ifid(en_ifid4), .en_idex(en_idex4), .en_exmem(en_exmem4),
    .en_memwb(en_memwb4), .flush_ifid(flush_ifid4), .flush_idex(flush_idex4),
    .flush_exmem(flush_exmem4), .halt(halt4), .state(state4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected control word: {pc_en, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex, fl_exmem, halt}
  function automatic logic [8:0] model_ctrl();
    logic dm, lu;
    dm = (dmemREN_mem | dmemWEN_mem) & ~dhit;
    lu = memRead_ex && regSel_ex != 0 && (regSel_ex == rs_id || regSel_ex == rt_id);
    if (nRST)                         return 9'b0_0000_111_0;
    if (m_state == 2'd3 || halt_wb)   return 9'b0_0000_000_1;
    if (dm)                           return 9'b0_0000_000_0;
    if (pcSrc_mem)                    return 9'b1_1111_111_0;
    if (lu)                           return 9'b0_0111_010_0;
    if (!ihit)                        return 9'b0_1111_100_0;
    return 9'b1_1111_000_0;
  endfunction

  task automatic set_idle();
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; dmemREN_mem = 1'b0; dmemWEN_mem = 1'b0;
    memRead_ex = 1'b0; regSel_ex = 5'd0; rs_id = 5'd1; rt_id = 5'd2;
    pcSrc_mem = 1'b0; halt_wb = 1'b0;
  endtask

  // One cycle: push expectation for the current inputs, compare mid-cycle, advance the model.
  task automatic step();
    logic [8:0]  ctrl, got_ctrl, got_ctrl4;
    logic [63:0] e;
    logic        dm, lu;
    ctrl = model_ctrl();
    exp_q.push_back({17'd0, ctrl, m_state, m_stall, m_flush, m_stall4});
    @(negedge CLK);
    e = exp_q.pop_front();
    got_ctrl  = {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, flush_exmem, halt};
    got_ctrl4 = {pc_en4, en_ifid4, en_idex4, en_exmem4, en_memwb4, flush_ifid4, flush_idex4, flush_exmem4, halt4};
    check_eq("ctrl", 32'(got_ctrl), 32'(e[46:38]));
    check_eq("ctrl_w4", 32'(got_ctrl4), 32'(e[46:38]));
    check_eq("state", 32'(state), 32'(e[37:36]));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(e[35:20]));
    check_eq("flush_cnt", 32'(flush_cnt), 32'(e[19:4]));
    check_eq("stall_cnt_w4", 32'(stall_cnt4), 32'(e[3:0]));
    @(posedge CLK);
    dm = (dmemREN_mem | dmemWEN_mem) & ~dhit;
    lu = memRead_ex && regSel_ex != 0 && (regSel_ex == rs_id || regSel_ex == rt_id);
    if (nRST) begin
      m_state = 2'd0; m_stall = 0; m_flush = 0; m_stall4 = 0;
    end else begin
      if (ctrl[8] == 1'b0 && ctrl[0] == 1'b0) begin
        if (m_stall != 16'hffff) m_stall = m_stall + 1;
        if (m_stall4 != 4'hf) m_stall4 = m_stall4 + 1;
      end
      if (m_state != 2'd3 && !halt_wb && !dm && pcSrc_mem && m_flush != 16'hffff)
        m_flush = m_flush + 1;
      if (m_state == 2'd3 || halt_wb) m_state = 2'd3;
      else if (dm)                    m_state = 2'd2;
      else if (lu && !pcSrc_mem)      m_state = 2'd1;
      else                            m_state = 2'd0;
    end
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    nRST = 1'b1;
    step();
    set_idle();
  endtask

  initial begin
    set_idle();
    nRST = 1'b1;
    m_state = 0; m_stall = 0; m_flush = 0; m_stall4 = 0;
    @(posedge CLK); #1;

    // reset held two cycles under random inputs
    for (int i = 0; i < 2; i++) begin
      {ihit, dhit, dmemREN_mem, dmemWEN_mem, memRead_ex, pcSrc_mem, halt_wb} = 7'($urandom_range(0, 127));
      regSel_ex = 5'($urandom_range(0, 31)); rs_id = 5'($urandom_range(0, 31)); rt_id = 5'($urandom_range(0, 31));
      nRST = 1'b1;
      step();
    end
    set_idle();
    step();

    // load-use, then register 0 which must not stall
    memRead_ex = 1'b1; regSel_ex = 5'd5; rs_id = 5'd5; step();
    set_idle(); step();
    memRead_ex = 1'b1; regSel_ex = 5'd0; rs_id = 5'd0; step();
    memRead_ex = 1'b1; regSel_ex = 5'd7; rt_id = 5'd7; step();
    set_idle(); step();

    // dcache miss for three cycles, then the hit
    do_reset();
    for (int i = 0; i < 3; i++) begin dmemREN_mem = 1'b1; dhit = 1'b0; step(); end
    dmemREN_mem = 1'b1; dhit = 1'b1; step();
    set_idle(); dmemWEN_mem = 1'b1; step();
    set_idle(); step();

    // branch flush over an icache miss; same with a dcache miss which must win
    pcSrc_mem = 1'b1; ihit = 1'b0; step();
    pcSrc_mem = 1'b1; ihit = 1'b0; dmemREN_mem = 1'b1; dhit = 1'b0; step();
    set_idle(); pcSrc_mem = 1'b1; memRead_ex = 1'b1; regSel_ex = 5'd3; rs_id = 5'd3; step();
    set_idle(); step();

    // random mix without halt
    for (int i = 0; i < 40; i++) begin
      ihit = 1'($urandom_range(0, 1)); dhit = 1'($urandom_range(0, 1));
      dmemREN_mem = ($urandom_range(0, 3) == 0); dmemWEN_mem = ($urandom_range(0, 5) == 0);
      memRead_ex = 1'($urandom_range(0, 1)); pcSrc_mem = ($urandom_range(0, 3) == 0);
      regSel_ex = 5'($urandom_range(0, 3)); rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
      halt_wb = 1'b0;
      step();
    end

    // halt is immediate and sticky; reset returns to RUN
    set_idle(); halt_wb = 1'b1; step();
    set_idle(); ihit = 1'b0; step();
    set_idle(); pcSrc_mem = 1'b1; dmemREN_mem = 1'b1; step();
    set_idle(); step();
    do_reset();
    step();

    // stall counter saturation on the narrow instance
    for (int i = 0; i < 20; i++) begin ihit = 1'b0; step(); end
    set_idle(); step();

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage pipeline (IF/ID/EX/MEM/WB). It sits directly upstream of the forwarding path.
- It decides, per cycle, which pipeline latches advance, hold, or are flushed. Its decisions therefore determine what the forwarding logic sees in EX/MEM and MEM/WB.
- It handles:
  - load-use stalls that forwarding cannot cover;
  - icache and dcache wait stalls;
  - taken-branch and jump flushes resolved in MEM;
  - halt.
- A registered FSM tracks the stall cause. Saturating counters record stall statistics.

Parameters:
CNT_W, 16, width of stall/flush statistic counters
REG_W, 5, register-select width

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  synchronous reset, active-high (asserted when 1, sampled on rising CLK)
ihit  input  1  icache returned instruction this cycle
dhit  input  1  dcache completed request this cycle
dmemREN_mem  input  1  load in MEM stage
dmemWEN_mem  input  1  store in MEM stage
memRead_ex  input  1  instruction in EX is a load
regSel_ex  input  REG_W  destination register of EX instruction
rs_id  input  REG_W  rs of ID instruction
rt_id  input  REG_W  rt of ID instruction
pcSrc_mem  input  1  taken branch/jump resolved in MEM
halt_wb  input  1  halt instruction reached WB
pc_en  output  1  PC register load enable
en_ifid  output  1  IF/ID latch enable
en_idex  output  1  ID/EX latch enable
en_exmem  output  1  EX/MEM latch enable
en_memwb  output  1  MEM/WB latch enable
flush_ifid  output  1  load NOP into IF/ID
flush_idex  output  1  load NOP into ID/EX
flush_exmem  output  1  load NOP into EX/MEM
halt  output  1  CPU halted, sticky
state  output  2  FSM state: 0 RUN, 1 LUSE, 2 DWAIT, 3 HALTED
stall_cnt  output  CNT_W  cycles with pc_en=0 while not HALTED, saturating
flush_cnt  output  CNT_W  taken pcSrc_mem events, saturating

Behaviour:
- Reset (nRST=1 at a rising edge):
  - state=RUN, halt=0, stall_cnt=0, flush_cnt=0.
  - While nRST=1, the combinational outputs are forced: pc_en=0, all en_*=0, all flush_*=1.
  - Reset mid-stall or while HALTED returns to RUN on the next edge.
- Definitions:
  - dmiss = (dmemREN_mem | dmemWEN_mem) & ~dhit
  - luse = memRead_ex & (regSel_ex != 0) & ((regSel_ex == rs_id) | (regSel_ex == rt_id))
- Control outputs are combinational from the current state and inputs. Priority, highest first:
  1. HALTED state, or halt_wb=1: all en_*=0, pc_en=0, flush_*=0, halt=1 (combinational on halt_wb; registered afterward).
  2. dmiss: freeze the whole pipeline. pc_en=0, all en_*=0, flush_*=0.
  3. pcSrc_mem: pc_en=1 (the target loads even if ihit=0). flush_ifid=flush_idex=flush_exmem=1. All en_*=1.
  4. luse: pc_en=0, en_ifid=0 (hold ID). flush_idex=1 (bubble into EX). en_exmem=en_memwb=1.
  5. ~ihit: pc_en=0, flush_ifid=1. en_idex=en_exmem=en_memwb=1.
  6. Otherwise: pc_en=1, all en_*=1, flush_*=0.
- A flush overrides an enable on the same latch: the NOP is loaded.
- FSM next state:
  - any state -> HALTED on halt_wb; HALTED is absorbing until reset.
  - else -> DWAIT if dmiss.
  - else -> LUSE if luse and not pcSrc_mem.
  - else -> RUN.
- The LUSE state lasts exactly one cycle. The inserted bubble clears memRead_ex, so luse cannot hold for two consecutive cycles unless the pipeline is frozen by dmiss (DWAIT has priority).
- Counters:
  - stall_cnt increments on every edge with pc_en=0, halt=0, and nRST=0.
  - flush_cnt increments on every edge with rule 3 active.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Register 0 never causes a load-use stall.

Test Plan:
- Reset: hold nRST=1 for 2 cycles with random inputs -> pc_en=0, all en=0, all flush=1. After release: state=0, stall_cnt=0, flush_cnt=0, halt=0.
- Load-use: memRead_ex=1, regSel_ex=5, rs_id=5, ihit=1 for one cycle -> pc_en=0, en_ifid=0, flush_idex=1, state=1 next cycle. With regSel_ex=0 instead -> no stall.
- Dcache miss: dmemREN_mem=1, dhit=0 for 3 cycles, then dhit=1 -> all en=0 for 3 cycles, state=2, stall_cnt=3. On the dhit cycle all en=1.
- Branch flush with icache miss: pcSrc_mem=1, ihit=0 -> pc_en=1, three flushes=1, flush_cnt +1. Same cycle plus dmiss=1 -> freeze wins, flush_cnt unchanged.
- Halt: halt_wb=1 pulse -> halt=1 immediately and sticky; state=3; all en=0. stall_cnt does not increment. nRST pulse -> RUN.
- Saturation: CNT_W=4, hold ~ihit for 20 cycles -> stall_cnt stops at 15.
